// File: rtl/spring_force_accumulator_if.sv
// Spring-result input stream and net-force output stream of the spring force accumulator.
// slave is the accumulator's view; master is the view of whatever drives springs and drains forces.
interface spring_force_accumulator_if #(
  parameter int NUM_POINTS = 8,
  parameter int FORCE_SIZE = 16
);
  localparam int IDX_W = $clog2(NUM_POINTS);

  logic                  spring_valid_in;
  logic                  spring_ready_out;
  logic [IDX_W-1:0]      idx_a_in;
  logic [IDX_W-1:0]      idx_b_in;
  logic [FORCE_SIZE-1:0] force_x_in;
  logic [FORCE_SIZE-1:0] force_y_in;
  logic                  frame_end_in;
  logic                  out_valid;
  logic                  out_ready_in;
  logic [IDX_W-1:0]      out_idx;
  logic [FORCE_SIZE-1:0] out_force_x;
  logic [FORCE_SIZE-1:0] out_force_y;
  logic                  out_last;
  logic                  error_out;

  modport slave (
    input  spring_valid_in, idx_a_in, idx_b_in, force_x_in, force_y_in, frame_end_in, out_ready_in,
    output spring_ready_out, out_valid, out_idx, out_force_x, out_force_y, out_last, error_out
  );

  modport master (
    output spring_valid_in, idx_a_in, idx_b_in, force_x_in, force_y_in, frame_end_in, out_ready_in,
    input  spring_ready_out, out_valid, out_idx, out_force_x, out_force_y, out_last, error_out
  );
endinterface

// File: rtl/spring_force_accumulator.sv
// Accumulates +F into endpoint B and -F into endpoint A per spring, then drains every
// point's saturated net force in index order on frame end, clearing entries as they leave.
module spring_force_accumulator #(
  parameter int NUM_POINTS = 8,
  parameter int FORCE_SIZE = 16,
  parameter int ACC_SIZE   = FORCE_SIZE + 4
) (
  input logic clk_in,
  input logic rst_in,
  spring_force_accumulator_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_POINTS);
  localparam int EXT   = ACC_SIZE + 1 - FORCE_SIZE;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_POINTS - 1);

  typedef enum logic {ACCUM, DRAIN} state_t;
  typedef logic signed [ACC_SIZE-1:0] acc_t;
  typedef logic signed [ACC_SIZE:0]   wide_t;

  // One guard bit above the accumulator: overflow iff the top two bits differ.
  function automatic logic ovf_w(wide_t v);
    return v[ACC_SIZE] != v[ACC_SIZE-1];
  endfunction

  function automatic acc_t sat_w(wide_t v);
    if (ovf_w(v)) return v[ACC_SIZE] ? {1'b1, {(ACC_SIZE-1){1'b0}}} : {1'b0, {(ACC_SIZE-1){1'b1}}};
    return v[ACC_SIZE-1:0];
  endfunction

  function automatic logic ovf_o(acc_t v);
    logic [ACC_SIZE-FORCE_SIZE:0] top;
    top = v[ACC_SIZE-1:FORCE_SIZE-1];
    return !((&top) || (~|top));
  endfunction

  function automatic logic [FORCE_SIZE-1:0] sat_o(acc_t v);
    if (ovf_o(v)) return v[ACC_SIZE-1] ? {1'b1, {(FORCE_SIZE-1){1'b0}}} : {1'b0, {(FORCE_SIZE-1){1'b1}}};
    return v[FORCE_SIZE-1:0];
  endfunction

  state_t           state, state_nxt;
  acc_t             acc_x [NUM_POINTS];
  acc_t             acc_y [NUM_POINTS];
  logic [IDX_W-1:0] cnt;
  logic             err;

  logic             drain, hs, accept, bad, same, upd, acc_ovf, out_ovf;
  logic [IDX_W-1:0] ra, rb;
  wide_t            fx, fy, nax, nay, nbx, nby;

  assign drain  = (state == DRAIN);
  assign hs     = drain && bus.out_ready_in;
  assign accept = bus.spring_valid_in && bus.spring_ready_out;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (bus.frame_end_in) state_nxt = DRAIN;
      DRAIN: if (hs && cnt == LAST) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    bus.spring_ready_out = !drain && !rst_in;
    bus.out_valid        = drain;
    bus.out_idx          = cnt;
    bus.out_last         = drain && (cnt == LAST);
    bus.out_force_x      = sat_o(acc_x[cnt]);
    bus.out_force_y      = sat_o(acc_y[cnt]);
    bus.error_out        = err;
  end

  // Bad indices are steered to entry 0 for the read so the array is never indexed out of range.
  always_comb begin
    bad     = (32'(bus.idx_a_in) >= NUM_POINTS) || (32'(bus.idx_b_in) >= NUM_POINTS);
    same    = (bus.idx_a_in == bus.idx_b_in);
    upd     = accept && !bad && !same;
    ra      = bad ? '0 : bus.idx_a_in;
    rb      = bad ? '0 : bus.idx_b_in;
    fx      = {{EXT{bus.force_x_in[FORCE_SIZE-1]}}, bus.force_x_in};
    fy      = {{EXT{bus.force_y_in[FORCE_SIZE-1]}}, bus.force_y_in};
    nbx     = {acc_x[rb][ACC_SIZE-1], acc_x[rb]} + fx;
    nby     = {acc_y[rb][ACC_SIZE-1], acc_y[rb]} + fy;
    nax     = {acc_x[ra][ACC_SIZE-1], acc_x[ra]} - fx;
    nay     = {acc_y[ra][ACC_SIZE-1], acc_y[ra]} - fy;
    acc_ovf = ovf_w(nbx) || ovf_w(nby) || ovf_w(nax) || ovf_w(nay);
    out_ovf = ovf_o(acc_x[cnt]) || ovf_o(acc_y[cnt]);
  end

  // Entries are plain flops updated at the accept edge, so back-to-back springs
  // on shared indices always read the already-updated value.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_POINTS; i++) begin
        acc_x[i] <= '0;
        acc_y[i] <= '0;
      end
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (upd) begin
        acc_x[rb] <= sat_w(nbx);
        acc_y[rb] <= sat_w(nby);
        acc_x[ra] <= sat_w(nax);
        acc_y[ra] <= sat_w(nay);
      end
      if (hs) begin
        acc_x[cnt] <= '0;
        acc_y[cnt] <= '0;
        cnt        <= (cnt == LAST) ? '0 : cnt + IDX_W'(1);
      end
      if ((accept && bad) || (upd && acc_ovf) || (drain && out_ovf)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spring_force_accumulator.sv
// Directed-vector bench: stimulus pushes expected drain words into a scoreboard,
// a negedge monitor compares every presented word against the queue head.
module tb_spring_force_accumulator;
  localparam int NP   = 9;
  localparam int FS   = 16;
  localparam int AMAX = 524287;
  localparam int AMIN = -524288;

  typedef struct { int idx; int fx; int fy; bit last; } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   mx [NP];
  int   my [NP];
  bit   err_exp = 1'b0;
  word_t sb [$];

  spring_force_accumulator_if #(.NUM_POINTS(NP), .FORCE_SIZE(FS)) bus ();
  spring_force_accumulator #(.NUM_POINTS(NP), .FORCE_SIZE(FS)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int acc_add(input int v, input int d);
    int s = v + d;
    if (s > AMAX) begin err_exp = 1'b1; return AMAX; end
    if (s < AMIN) begin err_exp = 1'b1; return AMIN; end
    return s;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767)  begin err_exp = 1'b1; return 32767; end
    if (v < -32768) begin err_exp = 1'b1; return -32768; end
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NP; i++) begin mx[i] = 0; my[i] = 0; end
  endtask

  task automatic send(input int a, input int b, input int fx, input int fy, input bit fe);
    bus.idx_a_in        = 4'(a);
    bus.idx_b_in        = 4'(b);
    bus.force_x_in      = 16'(fx);
    bus.force_y_in      = 16'(fy);
    bus.spring_valid_in = 1'b1;
    bus.frame_end_in    = fe;
    chk("spring_ready_accum", bus.spring_ready_out, 1);
    if (a >= NP || b >= NP) err_exp = 1'b1;
    else if (a != b) begin
      mx[b] = acc_add(mx[b], fx);  my[b] = acc_add(my[b], fy);
      mx[a] = acc_add(mx[a], -fx); my[a] = acc_add(my[a], -fy);
    end
    @(posedge clk); #1;
    bus.spring_valid_in = 1'b0;
    bus.frame_end_in    = 1'b0;
  endtask

  task automatic frame_end_only();
    bus.frame_end_in = 1'b1;
    @(posedge clk); #1;
    bus.frame_end_in = 1'b0;
  endtask

  task automatic push_drain(input int n);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.idx = i; w.fx = sat16(mx[i]); w.fy = sat16(my[i]); w.last = (i == NP - 1);
      sb.push_back(w);
    end
    model_clear();
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1,0,0...
  task automatic run_drain(input int mode);
    int cyc = 0;
    while (sb.size() > 0 && cyc < 300) begin
      bus.out_ready_in = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready_in = 1'b0;
    chk("drain_words_left", sb.size(), 0);
    sb.delete();
  endtask

  task automatic after_drain(input string nm);
    chk({nm, "_ready_after"}, bus.spring_ready_out, 1);
    chk({nm, "_valid_after"}, bus.out_valid, 0);
    chk({nm, "_error"}, bus.error_out, err_exp);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      chk("spring_ready_drain", bus.spring_ready_out, 0);
      if (sb.size() == 0) begin
        chk("unexpected_word_idx", bus.out_idx, -1);
      end else begin
        chk($sformatf("idx_w%0d", sb[0].idx), bus.out_idx, sb[0].idx);
        chk($sformatf("fx_w%0d", sb[0].idx), $signed(bus.out_force_x), sb[0].fx);
        chk($sformatf("fy_w%0d", sb[0].idx), $signed(bus.out_force_y), sb[0].fy);
        chk($sformatf("last_w%0d", sb[0].idx), bus.out_last, sb[0].last);
        if (bus.out_ready_in) void'(sb.pop_front());
      end
    end
  end

  initial begin
    bus.spring_valid_in = 1'b0;
    bus.idx_a_in = '0; bus.idx_b_in = '0;
    bus.force_x_in = '0; bus.force_y_in = '0;
    bus.frame_end_in = 1'b0;
    bus.out_ready_in = 1'b0;
    model_clear();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.spring_ready_out, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_idx", bus.out_idx, 0);
    chk("rst_fx", bus.out_force_x, 0);
    chk("rst_fy", bus.out_force_y, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_error", bus.error_out, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_release", bus.spring_ready_out, 1);

    // single spring
    send(1, 2, 100, -50, 1'b1);
    push_drain(NP);
    run_drain(0);
    after_drain("single");

    // back-to-back springs with shared indices, frame end with the last
    send(1, 2, 10, 0, 1'b0);
    send(2, 3, 5, 0, 1'b0);
    send(1, 2, 3, 0, 1'b1);
    push_drain(NP);
    run_drain(0);
    after_drain("b2b");

    // backpressure, then an empty frame
    send(3, 5, 7, 8, 1'b0);
    send(5, 3, 2, -1, 1'b1);
    push_drain(NP);
    run_drain(1);
    after_drain("stall");
    frame_end_only();
    push_drain(NP);
    run_drain(0);
    after_drain("empty");

    // a==b is harmless, out-of-range index is dropped and flagged
    send(4, 4, 50, 60, 1'b0);
    chk("same_idx_error", bus.error_out, 0);
    send(9, 2, 70, 0, 1'b0);
    chk("bad_idx_error", bus.error_out, 1);
    send(1, 12, 70, 0, 1'b1);
    push_drain(NP);
    run_drain(0);
    after_drain("badidx");

    // reset in the middle of a drain
    send(2, 6, 11, -3, 1'b1);
    push_drain(3);
    run_drain(0);
    chk("mid_valid", bus.out_valid, 1);
    chk("mid_idx", bus.out_idx, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_idx", bus.out_idx, 0);
    chk("mid_rst_ready", bus.spring_ready_out, 0);
    chk("mid_rst_error", bus.error_out, 0);
    model_clear();
    err_exp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_release_ready", bus.spring_ready_out, 1);
    frame_end_only();
    push_drain(NP);
    run_drain(0);
    after_drain("postrst");

    // accumulator and output saturation
    for (int k = 0; k < 19; k++) send(3, 0, 32767, 0, 1'b0);
    send(3, 0, 32767, 0, 1'b1);
    chk("sat_acc_error", bus.error_out, 1);
    push_drain(NP);
    run_drain(0);
    after_drain("sat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
